syn_fifo_rd_stream: RTL and testbench
=====================================

Name: syn_fifo_rd_stream

Overview:
- Read-side engine for syn_fifo.
- Drains the FIFO's rd_en/data_out/empty port, whose data is valid one cycle after rd_en.
- Presents the drained words on a valid/ready stream interface at full throughput (one word per clock).
- Sits between syn_fifo and any downstream consumer; holds an internal 2-entry buffer to absorb the FIFO read latency and downstream backpressure.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous flush: discard buffered and in-flight words.
- fifo_empty  in  1  syn_fifo empty flag.
- fifo_rd_en  out  1  syn_fifo read enable.
- fifo_data  in  DATA_WIDTH  syn_fifo data_out; valid the cycle after fifo_rd_en.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  DATA_WIDTH  stream word.
- buf_level  out  2  buffered word count, 0..2.

Behaviour:
- Reset values: m_valid=0, m_data=0, buf_level=0, fifo_rd_en=0, in-flight flag=0, both buffer entries=0.
- Reset may assert mid-transfer; any in-flight read is lost and no word is replayed.
- Handshake: a transfer occurs on a rising edge with m_valid&&m_ready.
  - While m_valid=1 and m_ready=0, m_data is held stable and m_valid stays 1.
  - m_valid never depends combinationally on m_ready.
- Buffer: 2-entry FIFO (head drives m_data, tail is the skid). inflight is a 1-bit register set the cycle after a fifo_rd_en issue.
- Read issue (combinational):
  - fifo_rd_en = !fifo_empty && !flush && (buf_level + inflight - (m_valid&&m_ready)) < 2.
  - Never asserted while fifo_empty=1.
  - Never overfills the buffer.
- Capture: when inflight=1, fifo_data is written into the buffer at that edge. Same-edge capture plus transfer leaves buf_level unchanged.
- Latency: fifo_rd_en high in cycle N gives m_valid=1 in cycle N+2 (buffer was empty).
- Throughput: with m_ready held 1 and the FIFO non-empty, m_valid stays high every cycle after the initial 2-cycle fill.
- Ordering: words leave in exact FIFO order. No drop or duplication except on flush or rst.
- Flush (cycle F):
  - At the F edge, buf_level goes to 0 and m_valid to 0.
  - A word arriving from a read issued in cycle F-1 is discarded.
  - fifo_rd_en=0 during F.
  - Reads resume in F+1.
  - A handshake in cycle F still counts as transferred.
- FIFO goes empty mid-stream: remaining buffered words drain, then m_valid drops. No bubble word is emitted.
- Simultaneous capture, transfer and issue in one cycle is legal and is the steady state.

Optional Feature:
- Macro SYN_FIFO_RD_STREAM_CNT_EN.
- When defined:
  - Adds output xfer_cnt[15:0], counting m_valid&&m_ready transfers.
  - Saturates at 16'hFFFF.
  - Cleared by rst; not cleared by flush.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package syn_fifo_pkg holds:
  - localparam BUF_DEPTH=2.
  - typedef for the buffer level (logic [1:0]).
  - XFER_CNT_W=16.
- One sub-module is natural: syn_fifo_skid2, the 2-entry buffer with push/pop/flush and level output.
- The read-issue/inflight logic stays in the top module.

Test Plan:
- Write 16 words 0x01..0x10 into syn_fifo, m_ready=1 throughout -> first m_valid 2 cycles after the first fifo_rd_en; then 16 consecutive beats 0x01..0x10, no gaps.
- Same 16 words, m_ready toggling 1,0,1,0 -> exact order 0x01..0x10; m_data stable on every stalled cycle; buf_level never exceeds 2; fifo_rd_en never high with fifo_empty=1.
- m_ready=0 for 20 cycles with 16 words queued -> exactly 2 reads issued, buf_level=2, m_data=0x01 held; after release, remaining 14 words drain in order.
- Flush asserted one cycle after a fifo_rd_en (word 0x05 in flight) -> 0x05 and buffered words discarded; m_valid=0 next cycle; the next delivered word is 0x06 onward, from the FIFO.
- rst pulse mid-stream (async, between clock edges) -> m_valid, fifo_rd_en and buf_level go to 0 immediately; after rst drops, streaming resumes from the current FIFO head.
- With SYN_FIFO_RD_STREAM_CNT_EN: after 16 transfers xfer_cnt=16; it stays 16 across a flush; it is 0 after rst.

Source files
------------

// File: rtl/syn_fifo_rd_stream_pkg.sv
// Shared constants and types for the syn_fifo read-side stream engine.
// Holds buffer depth, buffer level type and transfer counter width.
package syn_fifo_pkg;

   localparam int unsigned BUF_DEPTH  = 2;
   localparam int unsigned XFER_CNT_W = 16;

   typedef logic [1:0] level_t;

endpackage

// File: rtl/syn_fifo_rd_stream_if.sv
// Valid/ready stream bundle carrying drained FIFO words downstream.
// Ports: m_valid, m_ready, m_data; master drives valid/data, slave drives ready.
interface syn_fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );

endinterface

// File: rtl/syn_fifo_rd_stream_skid2.sv
// Two-entry buffer: head drives dout, tail absorbs one word of skid.
// Ports: clk, rst, flush, push/din, pop, dout, level (0..2).
module syn_fifo_skid2
   import syn_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output level_t                level
);

   logic [DATA_WIDTH-1:0] e0;
   logic [DATA_WIDTH-1:0] e1;
   level_t                lvl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0  <= '0;
         e1  <= '0;
         lvl <= 2'd0;
      end else if (flush) begin
         lvl <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (lvl == 2'd0) e0 <= din;
               else             e1 <= din;
               lvl <= lvl + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               lvl <= lvl - 2'd1;
            end
            2'b11: begin
               // level is unchanged; new word lands behind what remains
               if (lvl == 2'd1) begin
                  e0 <= din;
               end else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = e0;
   assign level = lvl;

endmodule

// File: rtl/syn_fifo_rd_stream.sv
// Drains syn_fifo (1-cycle read latency) onto a full-rate valid/ready stream.
// Ports: clk, rst, flush, fifo_empty/fifo_rd_en/fifo_data, m (stream), buf_level;
// xfer_cnt only when SYN_FIFO_RD_STREAM_CNT_EN is defined.
module syn_fifo_rd_stream
   import syn_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   syn_fifo_rd_stream_if.master  m,
   output level_t                buf_level
`ifdef SYN_FIFO_RD_STREAM_CNT_EN
   ,
   output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

   logic       inflight;
   logic       xfer;
   logic [2:0] pend;
   level_t     level;

   assign xfer = m.m_valid && m.m_ready;

   // words that will occupy the buffer after this edge if nothing new issues
   assign pend = {1'b0, level} + {2'b0, inflight} - {2'b0, xfer};

   assign fifo_rd_en = !rst && !fifo_empty && !flush
                     && (pend < 3'(BUF_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= fifo_rd_en;
   end

   syn_fifo_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (inflight),
      .pop   (xfer),
      .din   (fifo_data),
      .dout  (m.m_data),
      .level (level)
   );

   assign m.m_valid = (level != 2'd0);
   assign buf_level = level;

`ifdef SYN_FIFO_RD_STREAM_CNT_EN
   logic [XFER_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    cnt_q <= '0;
      else if (xfer && ~&cnt_q)   cnt_q <= cnt_q + 1'b1;
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_syn_fifo_rd_stream.sv
// Bench for syn_fifo_rd_stream: FIFO model plus a word-order reference queue.
// Covers latency, throughput, backpressure, flush, async reset, random traffic.
module tb_syn_fifo_rd_stream;
   import syn_fifo_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] fifo_data;
   level_t     buf_level;
`ifdef SYN_FIFO_RD_STREAM_CNT_EN
   logic [15:0] xfer_cnt;
`endif

   syn_fifo_rd_stream_if #(.DATA_WIDTH(8)) s_if ();

   syn_fifo_rd_stream #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .m          (s_if),
      .buf_level  (buf_level)
`ifdef SYN_FIFO_RD_STREAM_CNT_EN
      ,
      .xfer_cnt   (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] q[$];
   logic [7:0] expq[$];
   logic [7:0] dlv[$];
   int         cnt_model = 0;
   int         reads = 0;
   logic       s_rd, s_valid;
   logic       stall_prev = 1'b0;
   logic       flush_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // called just after a negedge with inputs set
   task automatic tick();
      logic [7:0] w;
      #3;
      s_rd    = fifo_rd_en;
      s_valid = s_if.m_valid;
      chk("rd_when_empty", {31'd0, s_rd && fifo_empty}, 32'd0);
      chk("level_max", {31'd0, buf_level <= 2'd2}, 32'd1);
      if (flush) chk("rd_in_flush", {31'd0, s_rd}, 32'd0);
      if (stall_prev && !flush_prev) begin
         chk("stall_valid", {31'd0, s_if.m_valid}, 32'd1);
         chk("stall_data", {24'd0, s_if.m_data}, {24'd0, stall_data});
      end
      if (s_if.m_valid && s_if.m_ready) begin
         if (expq.size() == 0) begin
            chk("xfer_underflow", 32'd1, 32'd0);
         end else begin
            w = expq.pop_front();
            chk("order", {24'd0, s_if.m_data}, {24'd0, w});
         end
         dlv.push_back(s_if.m_data);
         if (cnt_model < 65535) cnt_model++;
      end
      if (flush) expq.delete();
      if (s_rd && q.size() > 0) begin
         expq.push_back(q[0]);
         reads++;
      end
      stall_prev = s_if.m_valid && !s_if.m_ready;
      stall_data = s_if.m_data;
      flush_prev = flush;
      @(posedge clk);
      #1;
      if (s_rd && q.size() > 0) fifo_data = q.pop_front();
      fifo_empty = (q.size() == 0);
`ifdef SYN_FIFO_RD_STREAM_CNT_EN
      chk("xfer_cnt", {16'd0, xfer_cnt}, cnt_model);
`endif
      @(negedge clk);
   endtask

   // async reset pulse landing between clock edges
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", {31'd0, s_if.m_valid}, 32'd0);
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_level", {30'd0, buf_level}, 32'd0);
      chk("rst_data", {24'd0, s_if.m_data}, 32'd0);
`ifdef SYN_FIFO_RD_STREAM_CNT_EN
      chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
`endif
      expq.delete();
      cnt_model  = 0;
      stall_prev = 1'b0;
      flush_prev = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load16();
      for (int i = 1; i <= 16; i++) q.push_back(8'(i));
      fifo_empty = 1'b0;
   endtask

   task automatic chk_seq(string tag, int base, int first, int n);
      chk({tag, "_count"}, dlv.size() - base, n);
      for (int i = 0; i < n; i++)
         if (base + i < dlv.size())
            chk(tag, {24'd0, dlv[base+i]}, first + i);
   endtask

   initial begin
      int first_rd, first_v, last_v, base, head;
      rst        = 1'b1;
      flush      = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
      s_if.m_ready = 1'b0;
      @(negedge clk);
      #2;
      chk("reset_valid", {31'd0, s_if.m_valid}, 32'd0);
      chk("reset_data", {24'd0, s_if.m_data}, 32'd0);
      chk("reset_level", {30'd0, buf_level}, 32'd0);
      chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // full-rate streaming
      load16();
      s_if.m_ready = 1'b1;
      dlv.delete();
      first_rd = -1; first_v = -1; last_v = -1;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (s_rd && first_rd < 0) first_rd = c;
         if (s_valid) begin
            if (first_v < 0) first_v = c;
            last_v = c;
         end
      end
      chk("latency", first_v - first_rd, 32'd2);
      chk("no_gaps", last_v - first_v, 32'd15);
      chk_seq("stream", 0, 1, 16);

      // alternating backpressure
      load16();
      dlv.delete();
      for (int c = 0; c < 60; c++) begin
         s_if.m_ready = (c % 2 == 0);
         tick();
      end
      chk_seq("toggle", 0, 1, 16);

      // long stall
      load16();
      dlv.delete();
      s_if.m_ready = 1'b0;
      reads = 0;
      for (int c = 0; c < 20; c++) tick();
      chk("stall_reads", reads, 32'd2);
      chk("stall_level", {30'd0, buf_level}, 32'd2);
      chk("stall_head", {24'd0, s_if.m_data}, 32'd1);
      s_if.m_ready = 1'b1;
      for (int c = 0; c < 40; c++) tick();
      chk_seq("release", 0, 1, 16);

      // flush with word 5 in flight
      load16();
      dlv.delete();
      reads = 0;
      for (int c = 0; c < 30 && reads < 5; c++) tick();
      chk("reads_before_flush", reads, 32'd5);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_valid", {31'd0, s_if.m_valid}, 32'd0);
      base = dlv.size();
      for (int c = 0; c < 40; c++) tick();
      chk_seq("after_flush", base, 6, 11);

      // async reset mid-stream
      load16();
      dlv.delete();
      for (int c = 0; c < 6; c++) tick();
      do_reset();
      head = q[0];
      base = dlv.size();
      for (int c = 0; c < 40; c++) tick();
      chk_seq("after_rst", base, head, 17 - head);

      // random traffic with occasional flush
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) != 0 && q.size() < 32) begin
            q.push_back(8'($urandom_range(0, 255)));
            fifo_empty = 1'b0;
         end
         s_if.m_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 39) == 0);
         tick();
      end
      flush = 1'b0;
      s_if.m_ready = 1'b1;
      for (int c = 0; c < 80; c++) tick();
      chk("drain_exp_empty", expq.size(), 32'd0);
      chk("drain_valid", {31'd0, s_if.m_valid}, 32'd0);

`ifdef SYN_FIFO_RD_STREAM_CNT_EN
      do_reset();
      load16();
      for (int c = 0; c < 30; c++) tick();
      chk("cnt_16", {16'd0, xfer_cnt}, 32'd16);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("cnt_flush", {16'd0, xfer_cnt}, 32'd16);
      do_reset();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
